// File: rtl/xoodoo_pkg.sv
// Shared widths, round constants and plane helpers for the Xoodoo engine.
package xoodoo_pkg;

    localparam int LANE_W  = 32;
    localparam int PLANE_W = 128;
    localparam int STATE_W = 384;

    typedef logic [PLANE_W-1:0] plane_t;
    typedef logic [STATE_W-1:0] state_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } fsm_t;

    function automatic logic [LANE_W-1:0] rc_of(input logic [3:0] idx);
        logic [LANE_W-1:0] c;
        case (idx)
            4'd0:    c = 32'h058;
            4'd1:    c = 32'h038;
            4'd2:    c = 32'h3C0;
            4'd3:    c = 32'h0D0;
            4'd4:    c = 32'h120;
            4'd5:    c = 32'h014;
            4'd6:    c = 32'h060;
            4'd7:    c = 32'h02C;
            4'd8:    c = 32'h380;
            4'd9:    c = 32'h0F0;
            4'd10:   c = 32'h1A0;
            4'd11:   c = 32'h012;
            default: c = '0;
        endcase
        return c;
    endfunction

    function automatic plane_t plane_of(input state_t s, input int y);
        return s[PLANE_W*y +: PLANE_W];
    endfunction

    function automatic logic [LANE_W-1:0] lane_of(input plane_t p, input int x);
        return p[LANE_W*x +: LANE_W];
    endfunction

    function automatic logic [LANE_W-1:0] rotl(input logic [LANE_W-1:0] l,
                                               input int unsigned v);
        return (l << v) | (l >> (LANE_W - v));
    endfunction

    // Lane x moves to x+t mod 4, every lane rotated left by v.
    function automatic plane_t shift_plane(input plane_t p, input int t, input int v);
        plane_t r;
        r = '0;
        for (int x = 0; x < 4; x++) begin
            r[LANE_W*((x + t) % 4) +: LANE_W] = rotl(lane_of(p, x), v);
        end
        return r;
    endfunction

endpackage

// File: rtl/xoodoo_round.sv
// One combinational Xoodoo round: theta, rho-west, iota, chi, rho-east.
module xoodoo_round
    import xoodoo_pkg::*;
(
    input  logic [STATE_W-1:0] state,
    input  logic [LANE_W-1:0]  rc,
    output logic [STATE_W-1:0] result
);

    plane_t a0, a1, a2, p, e, b0, b1, b2;

    always_comb begin
        a0 = plane_of(state, 0);
        a1 = plane_of(state, 1);
        a2 = plane_of(state, 2);

        p  = a0 ^ a1 ^ a2;
        e  = shift_plane(p, 1, 5) ^ shift_plane(p, 1, 14);
        a0 = a0 ^ e;
        a1 = a1 ^ e;
        a2 = a2 ^ e;

        a1 = shift_plane(a1, 1, 0);
        a2 = shift_plane(a2, 0, 11);

        a0[LANE_W-1:0] = a0[LANE_W-1:0] ^ rc;

        b0 = ~a1 & a2;
        b1 = ~a2 & a0;
        b2 = ~a0 & a1;
        a0 = a0 ^ b0;
        a1 = a1 ^ b1;
        a2 = a2 ^ b2;

        a1 = shift_plane(a1, 0, 1);
        a2 = shift_plane(a2, 2, 8);

        result = {a2, a1, a0};
    end

endmodule

// File: rtl/xoodoo_permute.sv
// Iterative Xoodoo[NROUNDS] engine, one round per clock, single-cycle done pulse.
module xoodoo_permute
    import xoodoo_pkg::*;
#(
    parameter int NROUNDS = 12
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               xoodoo_enable,
    input  logic [STATE_W-1:0] state_in,
    output logic [STATE_W-1:0] state_out,
    output logic               xoodoo_complete,
    output logic               busy
);

    fsm_t              fsm_q, fsm_d;
    logic [3:0]        rnd;
    state_t            work;
    state_t            round_out;
    logic              complete;
    logic              last;

    assign last = (rnd == 4'(NROUNDS - 1));

    xoodoo_round u_round (
        .state  (work),
        .rc     (rc_of(4'(12 - NROUNDS) + rnd)),
        .result (round_out)
    );

    always_ff @(posedge clk) begin
        if (reset) fsm_q <= IDLE;
        else       fsm_q <= fsm_d;
    end

    always_comb begin
        fsm_d = fsm_q;
        unique case (fsm_q)
            IDLE: if (xoodoo_enable) fsm_d = RUN;
            RUN:  if (last)          fsm_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (fsm_q == RUN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            work     <= '0;
            rnd      <= '0;
            complete <= 1'b0;
        end else begin
            complete <= 1'b0;
            unique case (fsm_q)
                IDLE: begin
                    if (xoodoo_enable) begin
                        work <= state_in;
                        rnd  <= '0;
                    end
                end
                RUN: begin
                    work     <= round_out;
                    rnd      <= last ? '0 : rnd + 4'd1;
                    complete <= last;
                end
            endcase
        end
    end

    assign state_out       = work;
    assign xoodoo_complete = complete;

endmodule

// File: tb/tb_xoodoo_permute.sv
// Directed bench for xoodoo_permute against an independent lane-level Xoodoo model.
module tb_xoodoo_permute;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         en1 = 1'b0, en12 = 1'b0;
    logic [383:0] in1 = '0, in12 = '0;
    logic [383:0] out1, out12;
    logic         done1, done12, busy1, busy12;

    int errors = 0;
    int checks = 0;

    logic [31:0] rc_tab [12] = '{
        32'h058, 32'h038, 32'h3C0, 32'h0D0, 32'h120, 32'h014,
        32'h060, 32'h02C, 32'h380, 32'h0F0, 32'h1A0, 32'h012
    };

    always #5 clk = ~clk;

    xoodoo_permute #(.NROUNDS(1)) dut1 (
        .clk(clk), .reset(reset), .xoodoo_enable(en1), .state_in(in1),
        .state_out(out1), .xoodoo_complete(done1), .busy(busy1)
    );

    xoodoo_permute #(.NROUNDS(12)) dut12 (
        .clk(clk), .reset(reset), .xoodoo_enable(en12), .state_in(in12),
        .state_out(out12), .xoodoo_complete(done12), .busy(busy12)
    );

    task automatic check(input string tag, input logic [383:0] obs, input logic [383:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rol(input logic [31:0] v, input int n);
        return (v << n) | (v >> (32 - n));
    endfunction

    function automatic logic [383:0] model(input logic [383:0] s, input int nr);
        logic [31:0] a [3][4];
        logic [31:0] b [3][4];
        logic [31:0] p [4];
        logic [31:0] t [4];
        logic [383:0] r;
        for (int y = 0; y < 3; y++)
            for (int x = 0; x < 4; x++)
                a[y][x] = s[128*y + 32*x +: 32];
        for (int k = 0; k < nr; k++) begin
            for (int x = 0; x < 4; x++) p[x] = a[0][x] ^ a[1][x] ^ a[2][x];
            for (int x = 0; x < 4; x++) begin
                t[x] = rol(p[(x+3)%4], 5) ^ rol(p[(x+3)%4], 14);
            end
            for (int y = 0; y < 3; y++)
                for (int x = 0; x < 4; x++) a[y][x] ^= t[x];
            for (int x = 0; x < 4; x++) t[x] = a[1][(x+3)%4];
            for (int x = 0; x < 4; x++) begin
                a[1][x] = t[x];
                a[2][x] = rol(a[2][x], 11);
            end
            a[0][0] ^= rc_tab[12 - nr + k];
            for (int y = 0; y < 3; y++)
                for (int x = 0; x < 4; x++)
                    b[y][x] = ~a[(y+1)%3][x] & a[(y+2)%3][x];
            for (int y = 0; y < 3; y++)
                for (int x = 0; x < 4; x++) a[y][x] ^= b[y][x];
            for (int x = 0; x < 4; x++) t[x] = a[2][(x+2)%4];
            for (int x = 0; x < 4; x++) begin
                a[1][x] = rol(a[1][x], 1);
                a[2][x] = rol(t[x], 8);
            end
        end
        for (int y = 0; y < 3; y++)
            for (int x = 0; x < 4; x++)
                r[128*y + 32*x +: 32] = a[y][x];
        return r;
    endfunction

    // Called at posedge+1; returns in the cycle the complete pulse is seen.
    task automatic run12(input logic [383:0] s, output int lat, output logic [383:0] res);
        en12 = 1'b1;
        in12 = s;
        lat  = -1;
        res  = '0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            en12 = 1'b0;
            if (done12) begin
                lat = n;
                res = out12;
                break;
            end
        end
    endtask

    initial begin
        logic [383:0] s, s2, res, exp1;
        int lat, pulses, first_n;

        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Idle after reset
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("idle_out12", out12, '0);
            check("idle_done12", 384'(done12), '0);
            check("idle_busy12", 384'(busy12), '0);
            check("idle_out1", out1, '0);
        end

        // NROUNDS=1 on zero state
        exp1 = '0;
        exp1[31:0]    = 32'h0000_0012;
        exp1[159:128] = 32'h0000_0024;
        en1 = 1'b1;
        in1 = '0;
        lat = -1;
        for (int n = 1; n <= 10; n++) begin
            @(posedge clk); #1;
            en1 = 1'b0;
            if (done1) begin
                lat = n;
                break;
            end
        end
        check("r1_latency", 384'(lat), 384'(2));
        check("r1_result", out1, exp1);

        // Zero state plus random states, back-to-back
        for (int i = 0; i < 200; i++) begin
            s = '0;
            if (i != 0)
                for (int w = 0; w < 12; w++) s[32*w +: 32] = $urandom;
            run12(s, lat, res);
            check("r12_latency", 384'(lat), 384'(13));
            check("r12_result", res, model(s, 12));
        end

        // Pulse is one cycle and the result is held while idle
        s = res;
        @(posedge clk); #1;
        check("pulse_width", 384'(done12), '0);
        check("hold_out", out12, s);
        repeat (3) @(posedge clk);
        #1 check("hold_out_later", out12, s);

        // Enable re-pulsed mid-run is ignored
        for (int w = 0; w < 12; w++) s[32*w +: 32] = 32'h0101_0101 * (w + 3);
        en12 = 1'b1;
        in12 = s;
        pulses = 0;
        first_n = -1;
        for (int n = 1; n <= 30; n++) begin
            @(posedge clk); #1;
            en12 = (n == 3 || n == 7);
            in12 = ~s;
            if (done12) begin
                pulses++;
                if (first_n < 0) begin
                    first_n = n;
                    res = out12;
                end
            end
        end
        en12 = 1'b0;
        check("repulse_count", 384'(pulses), 384'(1));
        check("repulse_latency", 384'(first_n), 384'(13));
        check("repulse_result", res, model(s, 12));

        // Enable in the complete cycle starts the next permutation
        s  = {12{32'hDEAD_BEEF}};
        s2 = {12{32'h1234_5678}};
        run12(s, lat, res);
        check("b2b_first_latency", 384'(lat), 384'(13));
        check("b2b_first_result", res, model(s, 12));
        run12(s2, lat, res);
        check("b2b_second_latency", 384'(lat), 384'(13));
        check("b2b_second_result", res, model(s2, 12));

        // Reset mid-run aborts without a pulse
        @(posedge clk); #1;
        en12 = 1'b1;
        in12 = s;
        for (int n = 1; n <= 6; n++) begin
            @(posedge clk); #1;
            en12 = 1'b0;
        end
        check("abort_busy_before", 384'(busy12), 384'(1));
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("abort_busy", 384'(busy12), '0);
        check("abort_out", out12, '0);
        pulses = 0;
        for (int n = 0; n < 15; n++) begin
            @(posedge clk); #1;
            if (done12) pulses++;
        end
        check("abort_no_pulse", 384'(pulses), '0);
        run12(s2, lat, res);
        check("abort_new_latency", 384'(lat), 384'(13));
        check("abort_new_result", res, model(s2, 12));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
